dtc_apb_master: RTL and testbench

Upstream APB master for the DTC register path. Accepts single register commands on a valid/ready interface and runs each as an APB3-style SETUP/ACCESS transfer into the DTC register decoder. Returns one response per command: read data, or a timeout error flag if pready never arrives. One transfer is outstanding at a time.

---
 rtl/dtc_pkg.sv | 8 +
 rtl/dtc_apb_master_if.sv | 32 +++
 rtl/dtc_timeout_cnt.sv | 15 +
 rtl/dtc_apb_master.sv | 87 ++++++++
 tb/tb_dtc_apb_master.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and constants for the DTC register path masters
package dtc_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} dtc_state_e;
  localparam int APB_AWIDTH_DEF = 32;
  localparam int APB_DWIDTH_DEF = 32;
  localparam logic [31:0] DADD_ADDR = 32'h0;
  localparam logic [31:0] DSEL_ADDR = 32'h100;
endpackage

// File: rtl/dtc_apb_master_if.sv
// dtc_apb_master_if: command, response and APB signals of the DTC register master
interface dtc_apb_master_if
  import dtc_pkg::*;
#(
  parameter int AW = APB_AWIDTH_DEF,
  parameter int DW = APB_DWIDTH_DEF
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic [AW-1:0] paddr;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, paddr, penable, pwrite, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, paddr, penable, pwrite, pwdata
  );
endinterface

// File: rtl/dtc_timeout_cnt.sv
// dtc_timeout_cnt: ACCESS wait counter; last flags the cycle whose increment hits TIMEOUT_CYCLES
module dtc_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
  assign last = cnt_q == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/dtc_apb_master.sv
// dtc_apb_master: single-outstanding APB3 master with pready timeout and valid/ready command/response
module dtc_apb_master
  import dtc_pkg::*;
#(
  parameter int APB_AWIDTH     = APB_AWIDTH_DEF,
  parameter int APB_DWIDTH     = APB_DWIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  dtc_apb_master_if.master bus
);
  dtc_state_e            state_q, state_d;
  logic [APB_AWIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_DWIDTH-1:0] rdata_q, rdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  err_q, err_d;
  logic                  cnt_clr, cnt_en, cnt_last;

  dtc_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        paddr_d  = bus.cmd_addr;
        pwdata_d = bus.cmd_wdata;
        pwrite_d = bus.cmd_write;
        state_d  = SETUP;
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout landing in the same cycle
        cnt_en  = !bus.pready;
        rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
        err_d   = !bus.pready;
        state_d = (bus.pready || cnt_last) ? RESP : ACCESS;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready = state_q == IDLE;
  assign bus.psel      = state_q == SETUP || state_q == ACCESS;
  assign bus.penable   = state_q == ACCESS;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dtc_apb_master.sv
// tb_dtc_apb_master: transaction-timeline model plus wait-state slave checking dtc_apb_master every cycle
module tb_dtc_apb_master;
  import dtc_pkg::*;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_at_edge = 1'b1;
  dtc_apb_master_if #(.AW(32), .DW(32)) bus ();

  dtc_apb_master #(.APB_AWIDTH(32), .APB_DWIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= rst;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Slave memory (two registers, selected by address bit 8) and the model's view of it
  logic [31:0] smem [2];
  logic [31:0] mmem [2];
  int wait_cfg = 0;

  // Model: a command accepted at cycle c gives SETUP at c+1, ACCESS for L cycles,
  // then RESP until the response handshake; L and err follow from the slave wait count.
  bit          active = 0;
  int          k, L, txn_wait, acc, pen_cnt, rv_cnt, first_rv, txn_hs;
  int          cyc = 0;
  int          n_rsp = 0;
  logic        e_err, e_write, e_psel, e_pen, e_rv;
  logic [31:0] e_rdata, e_addr, e_wdata;
  int          rsp_hs_q[$], cmd_hs_q[$], rv_len_q[$], pen_q[$], lat_q[$];
  logic [31:0] rdata_log[$];
  logic        err_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_at_edge) begin
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("rst_psel", 32'(bus.psel), 0);
      chk("rst_penable", 32'(bus.penable), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_pwdata", bus.pwdata, 0);
      chk("rst_pwrite", 32'(bus.pwrite), 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      active = 0;
      acc = 0;
      bus.pready = 1'b0;
    end else begin
      if (active) k++;
      e_psel = active && k >= 1 && k <= 1 + L;
      e_pen  = active && k >= 2 && k <= 1 + L;
      e_rv   = active && k > 1 + L;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!active));
      chk("psel", 32'(bus.psel), 32'(e_psel));
      chk("penable", 32'(bus.penable), 32'(e_pen));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      if (e_psel) begin
        chk("paddr", bus.paddr, e_addr);
        chk("pwdata", bus.pwdata, e_wdata);
        chk("pwrite", 32'(bus.pwrite), 32'(e_write));
      end
      if (e_rv) begin
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        if (rv_cnt == 0) first_rv = cyc;
        rv_cnt++;
      end
      if (bus.penable) pen_cnt++;
      if (!active && bus.cmd_valid && !rst) begin
        active   = 1;
        k        = 0;
        txn_hs   = cyc;
        txn_wait = wait_cfg;
        pen_cnt  = 0;
        rv_cnt   = 0;
        e_write  = bus.cmd_write;
        e_addr   = bus.cmd_addr;
        e_wdata  = bus.cmd_wdata;
        e_err    = txn_wait >= T;
        L        = e_err ? T : txn_wait + 1;
        e_rdata  = (e_err || e_write) ? 32'h0 : mmem[e_addr[8]];
        if (!e_err && e_write) mmem[e_addr[8]] = e_wdata;
      end else if (e_rv && bus.rsp_ready && !rst) begin
        active = 0;
        rsp_hs_q.push_back(cyc);
        cmd_hs_q.push_back(txn_hs);
        rv_len_q.push_back(rv_cnt);
        pen_q.push_back(pen_cnt);
        lat_q.push_back(first_rv - txn_hs);
        rdata_log.push_back(bus.rsp_rdata);
        err_log.push_back(bus.rsp_err);
        n_rsp++;
      end
      if (rst) active = 0;
      if (bus.penable) begin
        bus.pready = acc == txn_wait;
        acc++;
        if (bus.pready && bus.pwrite) smem[bus.paddr[8]] = bus.pwdata;
      end else begin
        acc = 0;
        bus.pready = 1'b0;
      end
    end
    bus.prdata = smem[bus.paddr[8]];
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input int wt);
    bit ok = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    wait_cfg      = wt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("cmd_accept");
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int tgt);
    for (int i = 0; i < 400 && n_rsp < tgt; i++) @(posedge clk);
    if (n_rsp < tgt) fail_now("rsp_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int b;
  initial begin
    smem[0] = 32'h0;
    smem[1] = 32'h0000_00C3;
    mmem[0] = 32'h0;
    mmem[1] = 32'h0000_00C3;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // zero-wait write
    send(1'b1, DADD_ADDR, 32'hA5A5_0001, 0);
    wait_rsp(1);
    chk("wr_latency", 32'(lat_q[0]), 3);
    chk("wr_access_len", 32'(pen_q[0]), 1);
    chk("wr_rdata", rdata_log[0], 32'h0);
    chk("wr_err", 32'(err_log[0]), 0);

    // read with two wait states
    send(1'b0, DSEL_ADDR, 32'h0, 2);
    wait_rsp(2);
    chk("rd_access_len", 32'(pen_q[1]), 3);
    chk("rd_rdata", rdata_log[1], 32'h0000_00C3);
    chk("rd_err", 32'(err_log[1]), 0);

    // stuck slave times out, then pready on the last allowed cycle
    send(1'b0, DSEL_ADDR, 32'h0, 255);
    wait_rsp(3);
    chk("to_access_len", 32'(pen_q[2]), 4);
    chk("to_err", 32'(err_log[2]), 1);
    chk("to_rdata", rdata_log[2], 32'h0);
    send(1'b0, DSEL_ADDR, 32'h0, T - 1);
    wait_rsp(4);
    chk("late_access_len", 32'(pen_q[3]), 4);
    chk("late_err", 32'(err_log[3]), 0);
    chk("late_rdata", rdata_log[3], 32'h0000_00C3);

    // backpressure with a second command pending
    b = n_rsp;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    send(1'b1, DSEL_ADDR, 32'h0000_1234, 0);
    fork
      send(1'b0, DSEL_ADDR, 32'h0, 0);
      begin
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
      end
    join
    wait_rsp(b + 2);
    chk("bp_rsp_len", 32'(rv_len_q[b]), 6);
    chk("bp_next_accept_gap", 32'(cmd_hs_q[b + 1] - rsp_hs_q[b]), 1);
    chk("bp_read_back", rdata_log[b + 1], 32'h0000_1234);

    // reset during ACCESS discards the transfer
    b = n_rsp;
    send(1'b0, DADD_ADDR, 32'h0, 255);
    for (int i = 0; i < 20 && !bus.penable; i++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("abort_no_rsp", 32'(n_rsp), 32'(b));

    // back-to-back alternating write/read pairs
    b = n_rsp;
    for (int i = 0; i < 8; i++)
      send(i % 2 == 0, (i % 4 < 2) ? DADD_ADDR : DSEL_ADDR, 32'h1000 + 32'(i), 0);
    wait_rsp(b + 8);
    for (int i = 1; i < 8; i++) begin
      chk("b2b_accept_gap", 32'(cmd_hs_q[b + i] - cmd_hs_q[b + i - 1]), 4);
      chk("b2b_rsp_gap", 32'(rsp_hs_q[b + i] - rsp_hs_q[b + i - 1]), 4);
    end
    for (int i = 1; i < 8; i += 2) chk("b2b_read_data", rdata_log[b + i], 32'h1000 + 32'(i - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
